interrupt_priority_service: RTL and testbench
=============================================

# interrupt_priority_service

Clocked priority-resolution and in-service stage of the PIC, directly downstream of the interrupt request register. It takes the latched request vector and the mask register, resolves the highest-priority unmasked request under fully-nested, rotatable priority, and drives INT. It runs the two-pulse INTA acknowledge sequence, maintains the In-Service Register (ISR) and processes EOI commands. It returns a clear strobe to the request stage so edge-latched requests are consumed on acknowledge.

## Interface
- NUM_IR, 8, number of interrupt levels; fixed at 8, the level index is 3 bits
- Clk  in  1  system clock, all state changes on rising edge
- Rst_n  in  1  synchronous reset, active-low
- Int_Req_Reg  in  8  latched requests from the request stage, bit n = IRn
- Int_Mask_Reg  in  8  1 = level masked
- Inta_Pulse  in  1  one-cycle strobe per CPU INTA pulse, already synchronised
- Eoi_Nonspecific  in  1  one-cycle command: clear highest-priority ISR bit
- Eoi_Specific  in  1  one-cycle command: clear ISR bit Eoi_Level
- Eoi_Level  in  3  target level for specific EOI or Set_Priority
- Rotate_On_Eoi  in  1  when 1, the cleared level becomes lowest priority
- Set_Priority  in  1  one-cycle command: lowest priority := Eoi_Level
- Auto_Eoi  in  1  when 1, the ISR bit is cleared on the second INTA
- INT  out  1  interrupt request to CPU
- In_Service_Reg  out  8  current ISR
- Vector_Level  out  3  acknowledged level, valid with Vector_Valid
- Vector_Valid  out  1  one-cycle pulse on second INTA
- Clear_Irr  out  8  one-hot, one-cycle pulse clearing the granted IRR bit

## Operation
- Priority order starts at Lowest_Priority+1 (mod 8) and descends to Lowest_Priority. Reset value of Lowest_Priority is 7, giving IR0 highest.
- Candidate = highest-priority bit of Int_Req_Reg & ~Int_Mask_Reg. It is eligible only if strictly higher priority than the highest set ISR bit (fully nested). An equal or lower request is blocked.
- FSM states are IDLE and ACK1.
- IDLE
  - INT = eligible candidate exists.
  - On Inta_Pulse with a candidate: latch the candidate level, set its ISR bit, pulse Clear_Irr[level], go to ACK1.
  - On Inta_Pulse with no candidate (spurious): latch level 7, no ISR set, no Clear_Irr, go to ACK1.
- ACK1
  - INT = 0.
  - On Inta_Pulse: Vector_Valid = 1 and Vector_Level = latched level for one cycle.
  - If Auto_Eoi and not spurious: clear that ISR bit and apply the rotation rule.
  - Go to IDLE.
- Nonspecific EOI clears the highest-priority set ISR bit; it is a no-op if the ISR is 0. Specific EOI clears bit Eoi_Level.
- Rotation rule: if Rotate_On_Eoi is 1, Lowest_Priority := the cleared level.
- Set_Priority loads Lowest_Priority := Eoi_Level. If asserted with a rotating EOI in the same cycle, Set_Priority wins.
- Simultaneous EOI and first INTA: the ISR clear is applied first, then the set. If both target the same bit, the set wins. The INTA decision uses pre-edge registered ISR.
- Eligibility and rotation use current register values only. No combinational path from INTA to INT.

## Timing
- Reset values: INT 0, In_Service_Reg 0, Vector_Level 0, Vector_Valid 0, Clear_Irr 0, Lowest_Priority 7, state IDLE.
- Reset mid-handshake aborts to IDLE with ISR cleared and no Vector_Valid.
- INT is registered. It reflects a change in request, mask, ISR or priority one cycle after that change.
- INT drops the cycle after the first Inta_Pulse. It re-evaluates one cycle after returning to IDLE.
- Clear_Irr is high in the cycle after the first Inta_Pulse edge, for exactly 1 cycle.
- Vector_Valid is high in the cycle after the second Inta_Pulse edge, for exactly 1 cycle.
- Back-to-back Inta_Pulse in consecutive cycles is legal. Minimum acknowledge time is 2 cycles.
- An EOI takes effect on the ISR at the next edge. A blocked lower request asserts INT one cycle later.

## Structure
- Shared package pic_pkg holds: the FSM state encoding (IDLE, ACK1), the level type (3-bit), the SPURIOUS_LEVEL = 7 constant, and a rotate-left/rotate-right function used for priority mapping.
- One combinational sub-module, pic_rotating_priority, with inputs vec[7:0] and lowest[2:0] and outputs found and level[2:0]. It is instantiated twice: once for requests, once for the ISR.

## Test plan
- Reset, Int_Req_Reg=8'h00 → INT 0, ISR 8'h00. Set Int_Req_Reg=8'h24 → INT=1 next cycle. Two INTA → Clear_Irr=8'h04, ISR=8'h04, Vector_Level=2.
- ISR=8'h04, Int_Req_Reg=8'h20 → INT stays 0. Nonspecific EOI → ISR=8'h00, INT=1 one cycle later.
- Int_Req_Reg=8'h81, Int_Mask_Reg=8'h01 → grant level 7. With Auto_Eoi=1, after second INTA → ISR=8'h00.
- Rotate_On_Eoi=1: service IR3, then nonspecific EOI → Lowest_Priority=3. Int_Req_Reg=8'h09 → grant level 0 before 3. Int_Req_Reg=8'h30 → grant level 4.
- Request withdrawn before first INTA → spurious: Vector_Level=7, ISR unchanged, Clear_Irr=8'h00.
- Rst_n low between the two INTAs → state IDLE, ISR 8'h00, no Vector_Valid on the subsequent INTA.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types, constants and priority helpers for the PIC
// priority-resolution / in-service stage.
package pic_pkg;

    localparam int NUM_IR = 8;

    typedef logic [2:0] level_t;

    typedef enum logic {
        IDLE = 1'b0,
        ACK1 = 1'b1
    } pic_state_t;

    localparam level_t SPURIOUS_LEVEL = 3'd7;

    function automatic logic [NUM_IR-1:0] rotate_right(input logic [NUM_IR-1:0] v,
                                                       input level_t n);
        return NUM_IR'({v, v} >> n);
    endfunction

    function automatic logic [NUM_IR-1:0] rotate_left(input logic [NUM_IR-1:0] v,
                                                      input level_t n);
        return NUM_IR'({v, v} >> (level_t'(NUM_IR) - n));
    endfunction

    // Rank 0 is the highest priority level; rank 7 is the current lowest.
    function automatic level_t priority_rank(input level_t level, input level_t lowest);
        return level - lowest - 3'd1;
    endfunction

endpackage

// File: rtl/pic_rotating_priority.sv
// Combinational rotating-priority resolver: finds the highest-priority set bit
// of vec when priority descends from lowest+1 (mod 8) down to lowest.
module pic_rotating_priority
    import pic_pkg::*;
(
    input  logic [NUM_IR-1:0] vec,
    input  level_t            lowest,
    output logic              found,
    output level_t            level
);

    logic [NUM_IR-1:0] rotated;
    level_t            offset;

    // After rotation, bit 0 holds the highest-priority level.
    assign rotated = rotate_right(vec, lowest + 3'd1);

    always_comb begin
        offset = '0;
        for (int i = NUM_IR - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = level_t'(i);
            end
        end
    end

    assign found = |rotated;
    assign level = offset + lowest + 3'd1;

endmodule

// File: rtl/interrupt_priority_service.sv
// PIC priority resolution, INTA handshake, in-service register and EOI handling.
// Grants the highest-priority unmasked request under fully-nested rotating priority.
module interrupt_priority_service
    import pic_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [NUM_IR-1:0] Int_Req_Reg,
    input  logic [NUM_IR-1:0] Int_Mask_Reg,
    input  logic              Inta_Pulse,
    input  logic              Eoi_Nonspecific,
    input  logic              Eoi_Specific,
    input  logic [2:0]        Eoi_Level,
    input  logic              Rotate_On_Eoi,
    input  logic              Set_Priority,
    input  logic              Auto_Eoi,
    output logic              INT,
    output logic [NUM_IR-1:0] In_Service_Reg,
    output logic [2:0]        Vector_Level,
    output logic              Vector_Valid,
    output logic [NUM_IR-1:0] Clear_Irr
);

    pic_state_t        state_reg, state_next;
    logic [NUM_IR-1:0] isr_reg, isr_next;
    level_t            lowest_reg, lowest_next;
    logic              int_reg, int_next;
    level_t            latched_level_reg, latched_level_next;
    logic              spurious_reg, spurious_next;
    level_t            vector_level_reg, vector_level_next;
    logic              vector_valid_reg, vector_valid_next;
    logic [NUM_IR-1:0] clear_irr_reg, clear_irr_next;

    logic [NUM_IR-1:0] pending;
    logic [NUM_IR-1:0] eoi_clear, auto_clear, grant_set;
    logic              req_found, isr_found;
    level_t            req_level, isr_level;
    logic              eligible, grant, ack2, ack2_auto;

    assign pending = Int_Req_Reg & ~Int_Mask_Reg;

    pic_rotating_priority u_req_prio (
        .vec    (pending),
        .lowest (lowest_reg),
        .found  (req_found),
        .level  (req_level)
    );

    pic_rotating_priority u_isr_prio (
        .vec    (isr_reg),
        .lowest (lowest_reg),
        .found  (isr_found),
        .level  (isr_level)
    );

    // Fully nested: a request must strictly outrank everything in service.
    assign eligible  = req_found &&
                       (!isr_found ||
                        (priority_rank(req_level, lowest_reg) < priority_rank(isr_level, lowest_reg)));
    assign grant     = (state_reg == IDLE) && Inta_Pulse && eligible;
    assign ack2      = (state_reg == ACK1) && Inta_Pulse;
    assign ack2_auto = ack2 && Auto_Eoi && !spurious_reg;

    generate
        for (genvar gi = 0; gi < NUM_IR; gi++) begin : g_bit
            assign eoi_clear[gi]  = (Eoi_Nonspecific && isr_found && (isr_level == level_t'(gi))) ||
                                    (Eoi_Specific && (Eoi_Level == level_t'(gi)));
            assign auto_clear[gi] = ack2_auto && (latched_level_reg == level_t'(gi));
            assign grant_set[gi]  = grant && (req_level == level_t'(gi));
        end
    endgenerate

    // Clears first, then the grant, so a same-bit collision leaves the bit set.
    assign isr_next = (isr_reg & ~(eoi_clear | auto_clear)) | grant_set;

    // Later assignments take precedence: Set_Priority overrides any rotation.
    always_comb begin
        lowest_next = lowest_reg;
        if (ack2_auto && Rotate_On_Eoi) begin
            lowest_next = latched_level_reg;
        end
        if (Eoi_Nonspecific && isr_found && Rotate_On_Eoi) begin
            lowest_next = isr_level;
        end
        if (Eoi_Specific && Rotate_On_Eoi) begin
            lowest_next = Eoi_Level;
        end
        if (Set_Priority) begin
            lowest_next = Eoi_Level;
        end
    end

    always_comb begin
        state_next         = state_reg;
        int_next           = 1'b0;
        latched_level_next = latched_level_reg;
        spurious_next      = spurious_reg;
        vector_level_next  = vector_level_reg;
        vector_valid_next  = 1'b0;
        clear_irr_next     = '0;
        case (state_reg)
            IDLE: begin
                int_next = eligible && !Inta_Pulse;
                if (Inta_Pulse) begin
                    state_next         = ACK1;
                    latched_level_next = eligible ? req_level : SPURIOUS_LEVEL;
                    spurious_next      = !eligible;
                    clear_irr_next     = grant_set;
                end
            end
            ACK1: begin
                if (Inta_Pulse) begin
                    state_next        = IDLE;
                    vector_valid_next = 1'b1;
                    vector_level_next = latched_level_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_reg         <= IDLE;
            isr_reg           <= '0;
            lowest_reg        <= 3'd7;
            int_reg           <= 1'b0;
            latched_level_reg <= '0;
            spurious_reg      <= 1'b0;
            vector_level_reg  <= '0;
            vector_valid_reg  <= 1'b0;
            clear_irr_reg     <= '0;
        end else begin
            state_reg         <= state_next;
            isr_reg           <= isr_next;
            lowest_reg        <= lowest_next;
            int_reg           <= int_next;
            latched_level_reg <= latched_level_next;
            spurious_reg      <= spurious_next;
            vector_level_reg  <= vector_level_next;
            vector_valid_reg  <= vector_valid_next;
            clear_irr_reg     <= clear_irr_next;
        end
    end

    assign INT            = int_reg;
    assign In_Service_Reg = isr_reg;
    assign Vector_Level   = vector_level_reg;
    assign Vector_Valid   = vector_valid_reg;
    assign Clear_Irr      = clear_irr_reg;

endmodule

// File: tb/tb_interrupt_priority_service.sv
// Self-checking bench: directed vector table, a reset-mid-handshake sequence,
// and randomized stimulus against a behavioural priority/in-service model.
module tb_interrupt_priority_service;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req, mask;
    logic       inta, eoi_ns, eoi_sp;
    logic [2:0] eoi_lvl;
    logic       rot, setp, auto_eoi;

    logic       int_o;
    logic [7:0] isr_o;
    logic [2:0] vl_o;
    logic       vv_o;
    logic [7:0] clr_o;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    interrupt_priority_service dut (
        .Clk             (clk),
        .Rst_n           (rst_n),
        .Int_Req_Reg     (req),
        .Int_Mask_Reg    (mask),
        .Inta_Pulse      (inta),
        .Eoi_Nonspecific (eoi_ns),
        .Eoi_Specific    (eoi_sp),
        .Eoi_Level       (eoi_lvl),
        .Rotate_On_Eoi   (rot),
        .Set_Priority    (setp),
        .Auto_Eoi        (auto_eoi),
        .INT             (int_o),
        .In_Service_Reg  (isr_o),
        .Vector_Level    (vl_o),
        .Vector_Valid    (vv_o),
        .Clear_Irr       (clr_o)
    );

    typedef struct {
        logic [7:0] req;
        logic [7:0] mask;
        logic       inta;
        logic       ns;
        logic       sp;
        logic [2:0] lvl;
        logic       rot;
        logic       setp;
        logic       aut;
        logic       rstn;
        logic       e_int;
        logic [7:0] e_isr;
        logic [2:0] e_vl;
        logic       e_vv;
        logic [7:0] e_clr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [7:0] r, input logic [7:0] m, input logic ia,
                       input logic ns, input logic sp, input logic [2:0] lv,
                       input logic ro, input logic sprio, input logic au, input logic rs,
                       input logic ei, input logic [7:0] eisr, input logic [2:0] evl,
                       input logic evv, input logic [7:0] eclr);
        vec_t v;
        v.req = r; v.mask = m; v.inta = ia; v.ns = ns; v.sp = sp; v.lvl = lv;
        v.rot = ro; v.setp = sprio; v.aut = au; v.rstn = rs;
        v.e_int = ei; v.e_isr = eisr; v.e_vl = evl; v.e_vv = evv; v.e_clr = eclr;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic [7:0] r, input logic [7:0] m, input logic ia,
                         input logic ns, input logic sp, input logic [2:0] lv,
                         input logic ro, input logic sprio, input logic au, input logic rs);
        req = r; mask = m; inta = ia; eoi_ns = ns; eoi_sp = sp; eoi_lvl = lv;
        rot = ro; setp = sprio; auto_eoi = au; rst_n = rs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ei, input logic [7:0] eisr,
                             input logic [2:0] evl, input logic evv, input logic [7:0] eclr);
        vectors++;
        check({tag, ".INT"},          {7'd0, int_o}, {7'd0, ei});
        check({tag, ".ISR"},          isr_o, eisr);
        check({tag, ".Vector_Level"}, {5'd0, vl_o}, {5'd0, evl});
        check({tag, ".Vector_Valid"}, {7'd0, vv_o}, {7'd0, evv});
        check({tag, ".Clear_Irr"},    clr_o, eclr);
    endtask

    // ---------------- behavioural reference model ----------------
    bit [7:0] m_isr;
    int       m_low;
    bit       m_ack;
    int       m_lat;
    bit       m_spur;
    bit       m_int;
    bit [7:0] m_clr;
    int       m_vl;
    bit       m_vv;

    function automatic int top_level(input bit [7:0] v, input int low);
        for (int r = 0; r < 8; r++) begin
            int l;
            l = (low + 1 + r) % 8;
            if (v[l]) return l;
        end
        return -1;
    endfunction

    function automatic int rank_of(input int l, input int low);
        return (l - low + 7) % 8;
    endfunction

    task automatic model_step();
        int       cand, itop;
        bit       elig, was_ack;
        bit [7:0] nisr;
        int       nlow;
        if (!rst_n) begin
            m_isr = 0; m_low = 7; m_ack = 0; m_lat = 0; m_spur = 0;
            m_int = 0; m_clr = 0; m_vl = 0; m_vv = 0;
            return;
        end
        cand    = top_level(req & ~mask, m_low);
        itop    = top_level(m_isr, m_low);
        elig    = (cand >= 0) && ((itop < 0) || (rank_of(cand, m_low) < rank_of(itop, m_low)));
        was_ack = m_ack;
        nisr    = m_isr;
        nlow    = m_low;
        m_clr   = 0;
        m_vv    = 0;
        m_int   = 0;
        if (was_ack) begin
            if (inta) begin
                m_vv  = 1;
                m_vl  = m_lat;
                m_ack = 0;
                if (auto_eoi && !m_spur) begin
                    nisr[m_lat] = 0;
                    if (rot) nlow = m_lat;
                end
            end
        end else begin
            m_int = elig && !inta;
        end
        if (eoi_ns && itop >= 0) begin
            nisr[itop] = 0;
            if (rot) nlow = itop;
        end
        if (eoi_sp) begin
            nisr[eoi_lvl] = 0;
            if (rot) nlow = int'(eoi_lvl);
        end
        if (setp) nlow = int'(eoi_lvl);
        if (!was_ack && inta) begin
            m_ack = 1;
            if (elig) begin
                m_lat      = cand;
                m_spur     = 0;
                nisr[cand] = 1;
                m_clr[cand] = 1;
            end else begin
                m_lat  = 7;
                m_spur = 1;
            end
        end
        m_isr = nisr;
        m_low = nlow;
    endtask

    initial begin
        drive(8'h00, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 0);

        //   req    mask  ia ns sp lvl  ro sp au rs | int isr   vl  vv clr
        add(8'h00, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 0,  0, 8'h00, 3'd0, 0, 8'h00);
        add(8'h00, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 1,  0, 8'h00, 3'd0, 0, 8'h00);
        add(8'h24, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 1,  1, 8'h00, 3'd0, 0, 8'h00);
        add(8'h24, 8'h00, 1, 0, 0, 3'd0, 0, 0, 0, 1,  0, 8'h04, 3'd0, 0, 8'h04);
        add(8'h20, 8'h00, 1, 0, 0, 3'd0, 0, 0, 0, 1,  0, 8'h04, 3'd2, 1, 8'h00);
        add(8'h20, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 1,  0, 8'h04, 3'd2, 0, 8'h00);
        add(8'h20, 8'h00, 0, 1, 0, 3'd0, 0, 0, 0, 1,  0, 8'h00, 3'd2, 0, 8'h00);
        add(8'h20, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 1,  1, 8'h00, 3'd2, 0, 8'h00);
        add(8'h81, 8'h01, 0, 0, 0, 3'd0, 0, 0, 0, 1,  1, 8'h00, 3'd2, 0, 8'h00);
        add(8'h81, 8'h01, 1, 0, 0, 3'd0, 0, 0, 0, 1,  0, 8'h80, 3'd2, 0, 8'h80);
        add(8'h01, 8'h01, 1, 0, 0, 3'd0, 0, 0, 1, 1,  0, 8'h00, 3'd7, 1, 8'h00);
        add(8'h01, 8'h01, 0, 0, 0, 3'd0, 0, 0, 0, 1,  0, 8'h00, 3'd7, 0, 8'h00);
        add(8'h08, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 1,  1, 8'h00, 3'd7, 0, 8'h00);
        add(8'h08, 8'h00, 1, 0, 0, 3'd0, 0, 0, 0, 1,  0, 8'h08, 3'd7, 0, 8'h08);
        add(8'h00, 8'h00, 1, 0, 0, 3'd0, 0, 0, 0, 1,  0, 8'h08, 3'd3, 1, 8'h00);
        add(8'h00, 8'h00, 0, 1, 0, 3'd0, 1, 0, 0, 1,  0, 8'h00, 3'd3, 0, 8'h00);
        add(8'h09, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 1,  1, 8'h00, 3'd3, 0, 8'h00);
        add(8'h09, 8'h00, 1, 0, 0, 3'd0, 0, 0, 0, 1,  0, 8'h01, 3'd3, 0, 8'h01);
        add(8'h08, 8'h00, 1, 0, 0, 3'd0, 0, 0, 0, 1,  0, 8'h01, 3'd0, 1, 8'h00);
        add(8'h08, 8'h00, 0, 0, 1, 3'd0, 0, 0, 0, 1,  0, 8'h00, 3'd0, 0, 8'h00);
        add(8'h30, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 1,  1, 8'h00, 3'd0, 0, 8'h00);
        add(8'h30, 8'h00, 1, 0, 0, 3'd0, 0, 0, 0, 1,  0, 8'h10, 3'd0, 0, 8'h10);
        add(8'h20, 8'h00, 1, 0, 0, 3'd0, 0, 0, 0, 1,  0, 8'h10, 3'd4, 1, 8'h00);
        add(8'h20, 8'h00, 0, 0, 1, 3'd4, 0, 0, 0, 1,  0, 8'h00, 3'd4, 0, 8'h00);
        add(8'h02, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 1,  1, 8'h00, 3'd4, 0, 8'h00);
        add(8'h00, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 1,  0, 8'h00, 3'd4, 0, 8'h00);
        add(8'h00, 8'h00, 1, 0, 0, 3'd0, 0, 0, 0, 1,  0, 8'h00, 3'd4, 0, 8'h00);
        add(8'h00, 8'h00, 1, 0, 0, 3'd0, 0, 0, 0, 1,  0, 8'h00, 3'd7, 1, 8'h00);
        add(8'h00, 8'h00, 0, 0, 0, 3'd7, 0, 1, 0, 1,  0, 8'h00, 3'd7, 0, 8'h00);
        add(8'h81, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 1,  1, 8'h00, 3'd7, 0, 8'h00);
        add(8'h81, 8'h00, 1, 0, 0, 3'd0, 0, 0, 0, 1,  0, 8'h01, 3'd7, 0, 8'h01);
        add(8'h80, 8'h00, 1, 0, 0, 3'd0, 0, 0, 0, 1,  0, 8'h01, 3'd0, 1, 8'h00);
        add(8'h00, 8'h00, 0, 1, 0, 3'd3, 1, 1, 0, 1,  0, 8'h00, 3'd0, 0, 8'h00);
        add(8'h13, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 1,  1, 8'h00, 3'd0, 0, 8'h00);
        add(8'h13, 8'h00, 1, 0, 0, 3'd0, 0, 0, 0, 1,  0, 8'h10, 3'd0, 0, 8'h10);
        add(8'h03, 8'h00, 1, 0, 0, 3'd0, 0, 0, 0, 1,  0, 8'h10, 3'd4, 1, 8'h00);
        add(8'h00, 8'h00, 0, 0, 1, 3'd4, 0, 0, 0, 1,  0, 8'h00, 3'd4, 0, 8'h00);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].req, tbl[i].mask, tbl[i].inta, tbl[i].ns, tbl[i].sp, tbl[i].lvl,
                  tbl[i].rot, tbl[i].setp, tbl[i].aut, tbl[i].rstn);
            tick();
            check_all($sformatf("tbl%0d", i), tbl[i].e_int, tbl[i].e_isr, tbl[i].e_vl,
                      tbl[i].e_vv, tbl[i].e_clr);
            $display("tbl %0d: req=%h mask=%h inta=%0d -> INT=%0d ISR=%h VL=%0d VV=%0d CLR=%h",
                     i, tbl[i].req, tbl[i].mask, tbl[i].inta, int_o, isr_o, vl_o, vv_o, clr_o);
        end

        // Reset between the two INTA pulses aborts the handshake.
        drive(8'h04, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 1); tick();
        check_all("rst_mid.req", 1, 8'h00, 3'd4, 0, 8'h00);
        drive(8'h04, 8'h00, 1, 0, 0, 3'd0, 0, 0, 0, 1); tick();
        check_all("rst_mid.inta1", 0, 8'h04, 3'd4, 0, 8'h04);
        drive(8'h00, 8'h00, 0, 0, 0, 3'd0, 0, 0, 0, 0); tick();
        check_all("rst_mid.reset", 0, 8'h00, 3'd0, 0, 8'h00);
        drive(8'h00, 8'h00, 1, 0, 0, 3'd0, 0, 0, 0, 1); tick();
        check_all("rst_mid.inta_after", 0, 8'h00, 3'd0, 0, 8'h00);
        drive(8'h00, 8'h00, 1, 0, 0, 3'd0, 0, 0, 0, 1); tick();
        check_all("rst_mid.inta_second", 0, 8'h00, 3'd7, 1, 8'h00);
        $display("seq rst_mid: reset between INTAs, next INTA pair gives spurious VL=%0d", vl_o);

        // Randomized run against the behavioural model.
        for (int c = 0; c < 3000; c++) begin
            drive(8'($urandom), 8'($urandom) & 8'($urandom),
                  $urandom_range(0, 9) < 3, $urandom_range(0, 11) == 0,
                  $urandom_range(0, 15) == 0, 3'($urandom),
                  1'($urandom), $urandom_range(0, 29) == 0, 1'($urandom),
                  (c == 0) ? 1'b0 : ($urandom_range(0, 249) != 0));
            model_step();
            tick();
            check_all($sformatf("rnd%0d", c), m_int, m_isr, 3'(m_vl), m_vv, m_clr);
            if (vv_o) begin
                $display("rnd %0d: acknowledge VL=%0d ISR=%h", c, vl_o, isr_o);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
